// File: rtl/reg_file_param.sv
// Parametrised register file with $0 hardwired to zero, optional write-to-read
// forwarding and a per-register busy scoreboard for stalling on pending writebacks.
module reg_file_param #(
    parameter int WIDTH  = 16,
    parameter int AW     = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic [AW-1:0]    wr,
    input  logic [WIDTH-1:0] wd,
    input  logic             regwrite,
    input  logic             issue,
    input  logic [AW-1:0]    issue_reg,
    output logic             any_busy
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic w_fwd1;
    logic w_fwd2;
    logic w_iss1;
    logic w_iss2;

    assign w_fwd1 = regwrite && (wr == rr1) && (wr != {AW{1'b0}});
    assign w_fwd2 = regwrite && (wr == rr2) && (wr != {AW{1'b0}});
    assign w_iss1 = issue && (issue_reg == rr1);
    assign w_iss2 = issue && (issue_reg == rr2);

    // Register storage and busy flags; entry 0 is never written so it stays zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= {WIDTH{1'b0}};
            end
            r_busy <= {DEPTH{1'b0}};
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (regwrite && (wr == AW'(k))) begin
                    r_mem[k] <= wd;
                end
                // A fresh issue outranks the writeback that retires the older one.
                if (issue && (issue_reg == AW'(k))) begin
                    r_busy[k] <= 1'b1;
                end else if (regwrite && (wr == AW'(k))) begin
                    r_busy[k] <= 1'b0;
                end
            end
        end
    end

    // Read port 1 with optional same-cycle forwarding of the write data.
    always_comb begin
        rd1   = r_mem[rr1];
        busy1 = r_busy[rr1];
        if (!resetn) begin
            rd1   = {WIDTH{1'b0}};
            busy1 = 1'b0;
        end else if (BYPASS && w_fwd1) begin
            rd1   = wd;
            busy1 = w_iss1 ? r_busy[rr1] : 1'b0;
        end else begin
            rd1   = r_mem[rr1];
            busy1 = r_busy[rr1];
        end
    end

    // Read port 2 with optional same-cycle forwarding of the write data.
    always_comb begin
        rd2   = r_mem[rr2];
        busy2 = r_busy[rr2];
        if (!resetn) begin
            rd2   = {WIDTH{1'b0}};
            busy2 = 1'b0;
        end else if (BYPASS && w_fwd2) begin
            rd2   = wd;
            busy2 = w_iss2 ? r_busy[rr2] : 1'b0;
        end else begin
            rd2   = r_mem[rr2];
            busy2 = r_busy[rr2];
        end
    end

    assign any_busy = |r_busy;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: bypassing and non-bypassing 4x16 instances
// driven in lockstep, plus a separate 8x32 instance for the parameter sweep.
module tb_reg_file_param;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [1:0]  rr1, rr2, wr, issue_reg;
    logic [15:0] wd;
    logic        regwrite, issue;
    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_busy1, a_busy2, a_any, b_busy1, b_busy2, b_any;

    logic [2:0]  c_rr1, c_rr2, c_wr, c_issue_reg;
    logic [31:0] c_wd, c_rd1, c_rd2;
    logic        c_regwrite, c_issue, c_busy1, c_busy2, c_any;

    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic [15:0] mdl [4];
    int n_checks = 0;
    int n_fail   = 0;

    reg_file_param #(.WIDTH(16), .AW(2), .BYPASS(1'b1)) u_a (
        .clock(clk), .resetn(resetn), .rr1(rr1), .rr2(rr2), .rd1(a_rd1), .rd2(a_rd2),
        .busy1(a_busy1), .busy2(a_busy2), .wr(wr), .wd(wd), .regwrite(regwrite),
        .issue(issue), .issue_reg(issue_reg), .any_busy(a_any));

    reg_file_param #(.WIDTH(16), .AW(2), .BYPASS(1'b0)) u_b (
        .clock(clk), .resetn(resetn), .rr1(rr1), .rr2(rr2), .rd1(b_rd1), .rd2(b_rd2),
        .busy1(b_busy1), .busy2(b_busy2), .wr(wr), .wd(wd), .regwrite(regwrite),
        .issue(issue), .issue_reg(issue_reg), .any_busy(b_any));

    reg_file_param #(.WIDTH(32), .AW(3), .BYPASS(1'b1)) u_c (
        .clock(clk), .resetn(resetn), .rr1(c_rr1), .rr2(c_rr2), .rd1(c_rd1), .rd2(c_rd2),
        .busy1(c_busy1), .busy2(c_busy2), .wr(c_wr), .wd(c_wd), .regwrite(c_regwrite),
        .issue(c_issue), .issue_reg(c_issue_reg), .any_busy(c_any));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regwrite   = 1'b0;
        issue      = 1'b0;
        c_regwrite = 1'b0;
        c_issue    = 1'b0;
    endtask

    task automatic test_reset();
        regwrite = 1'b1; wr = 2'd1; wd = 16'h1234; issue = 1'b1; issue_reg = 2'd2;
        tick();
        idle(); rr1 = 2'd1; rr2 = 2'd2;
        exp_q.push_back(32'h1234); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL pre_reset_rd1: got %0h want %0h", a_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy2) !== e) begin n_fail++; $display("FAIL pre_reset_busy2: got %0h want %0h", a_busy2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_any) !== e) begin n_fail++; $display("FAIL pre_reset_any: got %0h want %0h", a_any, e); end
        #2 resetn = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL reset_rd1: got %0h want %0h", a_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy2) !== e) begin n_fail++; $display("FAIL reset_busy2: got %0h want %0h", a_busy2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_any) !== e) begin n_fail++; $display("FAIL reset_any: got %0h want %0h", a_any, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd1) !== e) begin n_fail++; $display("FAIL reset_b_rd1: got %0h want %0h", b_rd1, e); end
        regwrite = 1'b1; wr = 2'd1; wd = 16'hFFFF; issue = 1'b1; issue_reg = 2'd1;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL reset_nobypass_rd1: got %0h want %0h", a_rd1, e); end
        tick();
        resetn = 1'b1; idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL reset_ignored_wr: got %0h want %0h", a_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy1) !== e) begin n_fail++; $display("FAIL reset_ignored_issue: got %0h want %0h", a_busy1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_any) !== e) begin n_fail++; $display("FAIL reset_release_any: got %0h want %0h", a_any, e); end
    endtask

    task automatic test_write_read();
        regwrite = 1'b1; wr = 2'd2; wd = 16'h0005; rr1 = 2'd2;
        exp_q.push_back(32'd0); exp_q.push_back(32'd5);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd1) !== e) begin n_fail++; $display("FAIL wr_b_before_edge: got %0h want %0h", b_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL wr_a_before_edge: got %0h want %0h", a_rd1, e); end
        tick();
        idle();
        exp_q.push_back(32'd5); exp_q.push_back(32'd5);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL wr_a_after_edge: got %0h want %0h", a_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd1) !== e) begin n_fail++; $display("FAIL wr_b_after_edge: got %0h want %0h", b_rd1, e); end
        regwrite = 1'b1; wr = 2'd0; wd = 16'hFFFF; rr1 = 2'd0;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL r0_no_bypass: got %0h want %0h", a_rd1, e); end
        tick();
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL r0_a_stays_zero: got %0h want %0h", a_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd1) !== e) begin n_fail++; $display("FAIL r0_b_stays_zero: got %0h want %0h", b_rd1, e); end
    endtask

    task automatic test_bypass();
        regwrite = 1'b1; wr = 2'd3; wd = 16'hBEEF; rr1 = 2'd3; rr2 = 2'd3;
        exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL bypass_a_rd1: got %0h want %0h", a_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd2) !== e) begin n_fail++; $display("FAIL bypass_a_rd2: got %0h want %0h", a_rd2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd1) !== e) begin n_fail++; $display("FAIL nobypass_b_rd1: got %0h want %0h", b_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd2) !== e) begin n_fail++; $display("FAIL nobypass_b_rd2: got %0h want %0h", b_rd2, e); end
        tick();
        idle();
        exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd1) !== e) begin n_fail++; $display("FAIL nobypass_after_rd1: got %0h want %0h", b_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_rd2) !== e) begin n_fail++; $display("FAIL nobypass_after_rd2: got %0h want %0h", b_rd2, e); end
    endtask

    task automatic test_scoreboard();
        issue = 1'b1; issue_reg = 2'd2; rr1 = 2'd2;
        tick();
        idle();
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy1) !== e) begin n_fail++; $display("FAIL sb_busy_set: got %0h want %0h", a_busy1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_any) !== e) begin n_fail++; $display("FAIL sb_any_set: got %0h want %0h", a_any, e); end
        tick();
        tick();
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_busy1) !== e) begin n_fail++; $display("FAIL sb_busy_holds: got %0h want %0h", b_busy1, e); end
        regwrite = 1'b1; wr = 2'd2; wd = 16'hAAAA;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy1) !== e) begin n_fail++; $display("FAIL sb_busy_bypass: got %0h want %0h", a_busy1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_busy1) !== e) begin n_fail++; $display("FAIL sb_busy_nobypass: got %0h want %0h", b_busy1, e); end
        tick();
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'hAAAA);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy1) !== e) begin n_fail++; $display("FAIL sb_busy_clear: got %0h want %0h", a_busy1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_any) !== e) begin n_fail++; $display("FAIL sb_any_clear: got %0h want %0h", a_any, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_busy1) !== e) begin n_fail++; $display("FAIL sb_b_busy_clear: got %0h want %0h", b_busy1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL sb_writeback_data: got %0h want %0h", a_rd1, e); end
    endtask

    task automatic test_collision();
        issue = 1'b1; issue_reg = 2'd1; regwrite = 1'b1; wr = 2'd1; wd = 16'h0007; rr1 = 2'd1;
        tick();
        idle();
        exp_q.push_back(32'd7); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL coll_data: got %0h want %0h", a_rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy1) !== e) begin n_fail++; $display("FAIL coll_busy_a: got %0h want %0h", a_busy1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(b_busy1) !== e) begin n_fail++; $display("FAIL coll_busy_b: got %0h want %0h", b_busy1, e); end
        issue = 1'b1; issue_reg = 2'd3;
        tick();
        idle(); rr2 = 2'd3;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy2) !== e) begin n_fail++; $display("FAIL coll_r3_busy: got %0h want %0h", a_busy2, e); end
        issue = 1'b1; issue_reg = 2'd1; regwrite = 1'b1; wr = 2'd3; wd = 16'h3333;
        tick();
        idle();
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'h3333); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy1) !== e) begin n_fail++; $display("FAIL split_r1_busy: got %0h want %0h", a_busy1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_busy2) !== e) begin n_fail++; $display("FAIL split_r3_clear: got %0h want %0h", a_busy2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_rd2) !== e) begin n_fail++; $display("FAIL split_r3_data: got %0h want %0h", a_rd2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(a_any) !== e) begin n_fail++; $display("FAIL split_any: got %0h want %0h", a_any, e); end
        regwrite = 1'b1; wr = 2'd1; wd = 16'h0007;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        mdl[0] = 16'h0000; mdl[1] = 16'h0007; mdl[2] = 16'hAAAA; mdl[3] = 16'h3333;
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            regwrite = 1'b1; wr = 2'(i % 4); wd = d;
            if ((i % 4) != 0) mdl[i % 4] = d;
            tick();
        end
        idle();
        for (int r = 0; r < 4; r++) begin
            rr1 = 2'(r); rr2 = 2'(3 - r);
            exp_q.push_back(32'(mdl[r])); exp_q.push_back(32'(mdl[3 - r]));
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (32'(a_rd1) !== e) begin n_fail++; $display("FAIL b2b_a_rd1[%0d]: got %0h want %0h", r, a_rd1, e); end
            e = exp_q.pop_front(); n_checks++;
            if (32'(b_rd2) !== e) begin n_fail++; $display("FAIL b2b_b_rd2[%0d]: got %0h want %0h", 3 - r, b_rd2, e); end
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 8; k++) begin
            c_regwrite = 1'b1; c_wr = 3'(k); c_wd = 32'h1111 * 32'(k);
            c_issue = (k == 0); c_issue_reg = 3'd0;
            tick();
        end
        idle();
        for (int k = 0; k < 8; k++) begin
            c_rr1 = 3'(k); c_rr2 = 3'(k);
            exp_q.push_back((k == 0) ? 32'd0 : 32'h1111 * 32'(k)); exp_q.push_back(32'd0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (c_rd1 !== e) begin n_fail++; $display("FAIL sweep_rd[%0d]: got %0h want %0h", k, c_rd1, e); end
            e = exp_q.pop_front(); n_checks++;
            if (32'(c_busy2) !== e) begin n_fail++; $display("FAIL sweep_busy[%0d]: got %0h want %0h", k, c_busy2, e); end
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); n_checks++;
        if (32'(c_any) !== e) begin n_fail++; $display("FAIL sweep_any: got %0h want %0h", c_any, e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        rr1 = 2'd0; rr2 = 2'd0; wr = 2'd0; wd = 16'h0000; issue_reg = 2'd0;
        c_rr1 = 3'd0; c_rr2 = 3'd0; c_wr = 3'd0; c_wd = 32'h0; c_issue_reg = 3'd0;
        idle();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_back_to_back();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
